abuf_sched: RTL and testbench
=============================

Name: abuf_sched

Overview:
- Phase scheduler and feed controller for the head's activation buffer (abuf).
- Walks a programmed list of compute phases (control_state 1..8) in order. For each phase it issues control_state/update and a start pulse, meters exactly one row of input words per row, and counts finish_row pulses until the phase's row quota is met.
- Returns abuf to state 0 when the list completes, then pulses done.
- Sits between the upstream activation source (valid/ready) and abuf's unhandshaked in_data port.

Parameters:
- DATA_W, 128, data word width (abuf in_data width).
- NUM_PHASES, 8, number of phase slots; slot i maps to control_state i+1.
- ROW_W, 10, width of the per-phase row quota and row counter.
- WORD_W, 6, width of the words-per-row count (max 32 words; 0 = phase disabled).
- SETTLE_CYC, 2, wait cycles after abuf_start before feeding (abuf registers start, then its max counts).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_wr_en  in  1  write one phase-table entry
- cfg_wr_phase  in  3  slot index 0..7
- cfg_wr_words  in  WORD_W  words per row for that slot
- cfg_wr_rows  in  ROW_W  rows for that slot
- cfg_phase_mask  in  NUM_PHASES  enabled slots, sampled on run
- run  in  1  start pulse, ignored while busy
- busy  out  1  high from the cycle after an accepted run until done
- done  out  1  one-cycle pulse at end of sequence
- err  out  1  sticky: finish_row outside WAIT_ROW; cleared by run
- phase_idx  out  3  current slot
- row_cnt  out  ROW_W  rows completed in current phase
- src_data  in  DATA_W  upstream word
- src_vld  in  1  upstream valid
- src_rdy  out  1  upstream ready
- abuf_in_data  out  DATA_W  = src_data
- abuf_in_data_vld  out  1  src_vld && src_rdy
- abuf_control_state  out  32  phase code to abuf
- abuf_control_state_update  out  1  one-cycle load strobe
- abuf_start  out  1  one-cycle start
- abuf_finish_row  in  1  row complete from abuf
- perf_stall_cnt  out  32  see Optional Feature

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (any cycle, including mid-sequence):
  - FSM to IDLE.
  - All outputs 0, including abuf_control_state=0 and err=0.
  - Phase table cleared; counters cleared.
  - abuf is not explicitly driven to state 0 by reset; the system resets both blocks together.
- Phase table: NUM_PHASES entries of {words, rows}. cfg_wr_en writes take effect next cycle. Writes while busy are accepted but only affect phases not yet entered.
- FSM states: IDLE, SELECT, UPDATE, START, SETTLE, FEED, WAIT_ROW, CLEAR, DONE.
- IDLE:
  - run -> latch mask, idx=0, clear err -> SELECT.
  - run while busy is ignored.
- SELECT:
  - If slot idx is enabled with words!=0 and rows!=0 -> UPDATE.
  - Else if idx==NUM_PHASES-1 -> CLEAR.
  - Else idx++ (one slot per cycle).
- UPDATE: abuf_control_state=idx+1 with update=1 for one cycle -> START.
- START: abuf_start=1 for one cycle, row_cnt=0 -> SETTLE.
- SETTLE: SETTLE_CYC cycles -> FEED.
- FEED:
  - src_rdy=1 (decoded from state).
  - Each transfer increments word_cnt.
  - The transfer with word_cnt==words-1 clears word_cnt and goes to WAIT_ROW; src_rdy is low from the next cycle.
  - src_vld low stalls without penalty.
- WAIT_ROW:
  - src_rdy=0. On abuf_finish_row: row_cnt++.
  - If row_cnt==rows-1 -> advance to the next slot via SELECT, or to CLEAR if this was the last slot.
  - Else -> FEED.
  - abuf's reuse replay needs no input; the scheduler only waits.
- CLEAR: abuf_control_state=0 with update=1 for one cycle -> DONE.
- DONE: done=1 and busy=0 in the same cycle -> IDLE.
- Empty mask: run -> SELECT walks 8 slots -> CLEAR -> DONE. No start is issued.
- abuf_finish_row in any state other than WAIT_ROW sets err; it is not counted.
- Counters do not wrap: the row quota comparison is exact and word_cnt is bounded by words.

Optional Feature:
- Macro: ABUF_SCHED_PERF_EN.
- Defined: perf_stall_cnt increments on every FEED cycle with src_vld=0. It clears on accepted run and saturates at 2^32-1.
- Undefined: counter logic removed; perf_stall_cnt driven constant 0.

Decomposition:
- Shared package abuf_sched_pkg:
  - FSM state enum.
  - Phase code constants PH_IDLE=0 .. PH_8=8 matching abuf control_state encoding.
  - Phase-table entry struct {words, rows}.
- One natural sub-module: abuf_sched_tbl, the phase-table register file with write port and combinational read by idx.

Test Plan:
- Slot0 {words=4, rows=1}, mask=0x01, run, src_vld always 1 -> update with state 1, start, 4 beats, one finish_row, update with state 0, done; total beats 4, err=0.
- Slot2 {2,3}, slot5 {8,1}, mask=0x24 -> states 3 then 6; 2+2+2 then 8 beats; each FEED re-entered only after finish_row; done once.
- src_vld toggled 1/0 in FEED with PERF_EN -> beats still exact; perf_stall_cnt equals the number of low-vld FEED cycles.
- mask=0x00 -> no abuf_start; done exactly 11 cycles after run, preceded by update with state 0.
- Spurious finish_row during FEED -> err=1 held until next run; row_cnt unchanged.
- rst asserted mid-FEED -> next cycle all outputs 0, busy=0, src_rdy=0; new run succeeds after table rewrite.

Source files
------------

// File: rtl/abuf_sched_pkg.sv
// abuf_sched_pkg: shared types and constants for the abuf phase scheduler.
//   state_t        - scheduler FSM states
//   PH_*           - abuf control_state phase codes (0 = idle, 1..8 = phases)
//   phase_entry_t  - one phase-table entry {words, rows}
//   phase_code()   - maps a table slot index to its abuf phase code
// The entry field widths below must match the WORD_W / ROW_W parameters of
// abuf_sched and abuf_sched_tbl.
package abuf_sched_pkg;

    localparam int PKG_WORD_W = 6;
    localparam int PKG_ROW_W  = 10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SELECT,
        S_UPDATE,
        S_START,
        S_SETTLE,
        S_FEED,
        S_WAIT_ROW,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [31:0] PH_IDLE = 32'd0;
    localparam logic [31:0] PH_1    = 32'd1;
    localparam logic [31:0] PH_2    = 32'd2;
    localparam logic [31:0] PH_3    = 32'd3;
    localparam logic [31:0] PH_4    = 32'd4;
    localparam logic [31:0] PH_5    = 32'd5;
    localparam logic [31:0] PH_6    = 32'd6;
    localparam logic [31:0] PH_7    = 32'd7;
    localparam logic [31:0] PH_8    = 32'd8;

    typedef struct packed {
        logic [PKG_WORD_W-1:0] words;
        logic [PKG_ROW_W-1:0]  rows;
    } phase_entry_t;

    // Slot i runs abuf in control_state i+1.
    function automatic logic [31:0] phase_code(input logic [2:0] idx);
        return 32'(idx) + PH_1;
    endfunction

endpackage

// File: rtl/abuf_sched_tbl.sv
// abuf_sched_tbl: phase-table register file.
//   clk, rst      - clock, synchronous active-high reset (clears all entries)
//   wr_en/wr_idx  - write strobe and slot index
//   wr_entry      - {words, rows} to store; visible on the read port next cycle
//   rd_idx        - combinational read slot index
//   rd_entry      - entry stored at rd_idx
module abuf_sched_tbl
    import abuf_sched_pkg::*;
#(
    parameter int NUM_PHASES = 8,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  phase_entry_t     wr_entry,
    input  logic [IDX_W-1:0] rd_idx,
    output phase_entry_t     rd_entry
);

    phase_entry_t tbl [NUM_PHASES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                tbl[i] <= '0;
            end
        end else if (wr_en) begin
            tbl[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = tbl[rd_idx];

endmodule

// File: rtl/abuf_sched.sv
// abuf_sched: phase scheduler and feed controller for the activation buffer.
// Walks the enabled phase slots in order; for each it loads the abuf phase
// code, pulses start, meters one row of input words at a time and counts
// finish_row pulses until the row quota is met, then returns abuf to phase 0
// and pulses done.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   cfg_wr_*                     - phase-table write port
//   cfg_phase_mask               - enabled slots, sampled on an accepted run
//   run / busy / done            - sequence control and status
//   err                          - sticky: finish_row seen outside WAIT_ROW
//   phase_idx, row_cnt           - progress status
//   src_data/src_vld/src_rdy     - upstream valid/ready word stream
//   abuf_in_data(_vld)           - unhandshaked word feed into abuf
//   abuf_control_state(_update)  - phase code and its load strobe
//   abuf_start, abuf_finish_row  - per-phase start and per-row completion
//   perf_stall_cnt               - FEED cycles starved by upstream
// Optional feature: define ABUF_SCHED_PERF_EN to build the stall counter;
// otherwise perf_stall_cnt is tied to 0.
module abuf_sched
    import abuf_sched_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int NUM_PHASES = 8,
    parameter int ROW_W      = PKG_ROW_W,
    parameter int WORD_W     = PKG_WORD_W,
    parameter int SETTLE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr_en,
    input  logic [2:0]            cfg_wr_phase,
    input  logic [WORD_W-1:0]     cfg_wr_words,
    input  logic [ROW_W-1:0]      cfg_wr_rows,
    input  logic [NUM_PHASES-1:0] cfg_phase_mask,
    input  logic                  run,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            phase_idx,
    output logic [ROW_W-1:0]      row_cnt,
    input  logic [DATA_W-1:0]     src_data,
    input  logic                  src_vld,
    output logic                  src_rdy,
    output logic [DATA_W-1:0]     abuf_in_data,
    output logic                  abuf_in_data_vld,
    output logic [31:0]           abuf_control_state,
    output logic                  abuf_control_state_update,
    output logic                  abuf_start,
    input  logic                  abuf_finish_row,
    output logic [31:0]           perf_stall_cnt
);

    // SETTLE always lasts at least one cycle.
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYC > 1) ? SETTLE_CYC - 1 : 0);
    localparam logic [2:0] IDX_LAST = 3'(NUM_PHASES - 1);

    state_t                state, state_nxt;
    logic [2:0]            idx;
    logic [NUM_PHASES-1:0] mask;
    phase_entry_t          rd_entry, cur;
    phase_entry_t          wr_entry;
    logic [WORD_W-1:0]     word_cnt;
    logic [SET_W-1:0]      settle_cnt;
    logic [31:0]           ctl_state;
    logic                  done_q, err_q;

    logic slot_ok, last_slot, word_last, row_last, xfer, run_acc;

    assign wr_entry = '{words: cfg_wr_words, rows: cfg_wr_rows};

    abuf_sched_tbl #(.NUM_PHASES(NUM_PHASES), .IDX_W(3)) u_tbl (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cfg_wr_en),
        .wr_idx   (cfg_wr_phase),
        .wr_entry (wr_entry),
        .rd_idx   (idx),
        .rd_entry (rd_entry)
    );

    // Slot eligibility reads the live table, so writes made while busy land
    // for slots not yet reached; the entered slot's entry is latched in cur.
    assign slot_ok   = mask[idx] && (rd_entry.words != '0) && (rd_entry.rows != '0);
    assign last_slot = (idx == IDX_LAST);
    assign word_last = (word_cnt == cur.words - WORD_W'(1));
    assign row_last  = (row_cnt == cur.rows - ROW_W'(1));
    assign xfer      = (state == S_FEED) && src_vld;
    assign run_acc   = (state == S_IDLE) && run;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (run) state_nxt = S_SELECT;
            S_SELECT: begin
                if (slot_ok)        state_nxt = S_UPDATE;
                else if (last_slot) state_nxt = S_CLEAR;
            end
            S_UPDATE:   state_nxt = S_START;
            S_START:    state_nxt = S_SETTLE;
            S_SETTLE:   if (settle_cnt == SET_LAST) state_nxt = S_FEED;
            S_FEED:     if (xfer && word_last) state_nxt = S_WAIT_ROW;
            S_WAIT_ROW: begin
                if (abuf_finish_row) begin
                    if (!row_last)      state_nxt = S_FEED;
                    else if (last_slot) state_nxt = S_CLEAR;
                    else                state_nxt = S_SELECT;
                end
            end
            S_CLEAR:    state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            mask       <= '0;
            cur        <= '0;
            word_cnt   <= '0;
            row_cnt    <= '0;
            settle_cnt <= '0;
            ctl_state  <= PH_IDLE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state  <= state_nxt;
            // done trails the DONE state by a cycle so it lands with busy low.
            done_q <= (state == S_DONE);

            if (run_acc)
                err_q <= 1'b0;
            else if (abuf_finish_row && state != S_WAIT_ROW)
                err_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (run) begin
                        mask <= cfg_phase_mask;
                        idx  <= '0;
                    end
                end
                // control_state is loaded on the way into UPDATE/CLEAR so the
                // new code and the update strobe reach abuf in the same cycle.
                S_SELECT: begin
                    if (slot_ok) begin
                        cur       <= rd_entry;
                        ctl_state <= phase_code(idx);
                    end else if (!last_slot) begin
                        idx <= idx + 3'd1;
                    end else begin
                        ctl_state <= PH_IDLE;
                    end
                end
                S_START: begin
                    row_cnt    <= '0;
                    word_cnt   <= '0;
                    settle_cnt <= '0;
                end
                S_SETTLE: settle_cnt <= settle_cnt + SET_W'(1);
                S_FEED: begin
                    if (xfer) word_cnt <= word_last ? '0 : word_cnt + WORD_W'(1);
                end
                S_WAIT_ROW: begin
                    if (abuf_finish_row) begin
                        row_cnt <= row_cnt + ROW_W'(1);
                        if (row_last) begin
                            if (!last_slot) idx <= idx + 3'd1;
                            else            ctl_state <= PH_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy                      = (state != S_IDLE);
    assign done                      = done_q;
    assign err                       = err_q;
    assign phase_idx                 = idx;
    assign src_rdy                   = (state == S_FEED);
    assign abuf_in_data              = src_data;
    assign abuf_in_data_vld          = xfer;
    assign abuf_control_state        = ctl_state;
    assign abuf_control_state_update = (state == S_UPDATE) || (state == S_CLEAR);
    assign abuf_start                = (state == S_START);

`ifdef ABUF_SCHED_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk) begin
        if (rst || run_acc)
            stall_q <= '0;
        else if (state == S_FEED && !src_vld && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end
    assign perf_stall_cnt = stall_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_abuf_sched.sv
module tb_abuf_sched;

`ifdef ABUF_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_wr_en;
    logic [2:0]   cfg_wr_phase;
    logic [5:0]   cfg_wr_words;
    logic [9:0]   cfg_wr_rows;
    logic [7:0]   cfg_phase_mask;
    logic         run;
    logic         busy, done, err;
    logic [2:0]   phase_idx;
    logic [9:0]   row_cnt;
    logic [127:0] src_data;
    logic         src_vld;
    logic         src_rdy;
    logic [127:0] abuf_in_data;
    logic         abuf_in_data_vld;
    logic [31:0]  abuf_control_state;
    logic         abuf_control_state_update;
    logic         abuf_start;
    logic         abuf_finish_row;
    logic [31:0]  perf_stall_cnt;

    abuf_sched dut (
        .clk(clk), .rst(rst),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_phase(cfg_wr_phase),
        .cfg_wr_words(cfg_wr_words), .cfg_wr_rows(cfg_wr_rows),
        .cfg_phase_mask(cfg_phase_mask), .run(run),
        .busy(busy), .done(done), .err(err),
        .phase_idx(phase_idx), .row_cnt(row_cnt),
        .src_data(src_data), .src_vld(src_vld), .src_rdy(src_rdy),
        .abuf_in_data(abuf_in_data), .abuf_in_data_vld(abuf_in_data_vld),
        .abuf_control_state(abuf_control_state),
        .abuf_control_state_update(abuf_control_state_update),
        .abuf_start(abuf_start), .abuf_finish_row(abuf_finish_row),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bench-side model of abuf: counts events and answers each completed
    // row with finish_row a few cycles later.
    int       tb_words [0:8];
    int       beats = 0, starts = 0, dones = 0, stalls = 0, viol = 0;
    int       upd_n = 0;
    logic [31:0] upd_log [0:63];
    int       row_beats = 0, pend = 0;
    bit       waiting = 0;
    bit       fr_force = 0;

    initial abuf_finish_row = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            row_beats = 0; pend = 0; waiting = 0;
            abuf_finish_row = 1'b0;
        end else begin
            if (abuf_finish_row) waiting = 0;
            if (pend > 0) pend--;
            if (abuf_in_data_vld) begin
                beats++;
                if (waiting) viol++;
                row_beats++;
                if (abuf_control_state < 9 && row_beats == tb_words[abuf_control_state]) begin
                    row_beats = 0;
                    waiting = 1;
                    pend = 3;
                end
            end
            if (abuf_start) starts++;
            if (abuf_control_state_update && upd_n < 64) begin
                upd_log[upd_n] = abuf_control_state;
                upd_n++;
            end
            if (done) dones++;
            if (src_rdy && !src_vld) stalls++;
            abuf_finish_row = (pend == 1) || fr_force;
        end
    end

    task automatic wr_slot(input int slot, input int w, input int r);
        cfg_wr_en = 1'b1;
        cfg_wr_phase = 3'(slot);
        cfg_wr_words = 6'(w);
        cfg_wr_rows = 10'(r);
        tb_words[slot + 1] = w;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output int n);
        bit seen;
        seen = 0;
        n = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_rdy(input string tag, input int bound);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (src_rdy) seen = 1;
        end
        if (!seen) chk({tag, "_rdy_timeout"}, 0, 1);
    endtask

    int b_beats, b_starts, b_dones, b_stalls, b_upd, b_viol, n;

    task automatic snap();
        b_beats = beats; b_starts = starts; b_dones = dones;
        b_stalls = stalls; b_upd = upd_n; b_viol = viol;
    endtask

    initial begin
        for (int i = 0; i < 9; i++) tb_words[i] = 0;
        rst = 1'b1; cfg_wr_en = 0; cfg_wr_phase = 0; cfg_wr_words = 0;
        cfg_wr_rows = 0; cfg_phase_mask = 0; run = 0; src_vld = 0;
        src_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdy", src_rdy, 0);
        chk("rst_ctl", abuf_control_state, 0);
        chk("rst_rowcnt", row_cnt, 0);
        chk("rst_perf", perf_stall_cnt, 0);
        chk("data_pass", abuf_in_data, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);

        // Single phase, one row of 4 words, upstream always valid.
        @(posedge clk); #1;
        wr_slot(0, 4, 1);
        cfg_phase_mask = 8'h01;
        src_vld = 1'b1;
        snap();
        pulse_run();
        @(negedge clk);
        chk("t1_busy", busy, 1);
        wait_done("t1", 200, n);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_beats", beats - b_beats, 4);
        chk("t1_starts", starts - b_starts, 1);
        chk("t1_nupd", upd_n - b_upd, 2);
        chk("t1_upd0", upd_log[b_upd], 1);
        chk("t1_upd1", upd_log[b_upd + 1], 0);
        chk("t1_err", err, 0);
        chk("t1_viol", viol - b_viol, 0);

        // Two phases: slot2 {2 words, 3 rows}, slot5 {8 words, 1 row}.
        @(posedge clk); #1;
        wr_slot(2, 2, 3);
        wr_slot(5, 8, 1);
        cfg_phase_mask = 8'h24;
        snap();
        pulse_run();
        wait_done("t2", 400, n);
        chk("t2_beats", beats - b_beats, 14);
        chk("t2_starts", starts - b_starts, 2);
        chk("t2_nupd", upd_n - b_upd, 3);
        chk("t2_upd0", upd_log[b_upd], 3);
        chk("t2_upd1", upd_log[b_upd + 1], 6);
        chk("t2_upd2", upd_log[b_upd + 2], 0);
        chk("t2_viol", viol - b_viol, 0);
        chk("t2_rowcnt", row_cnt, 1);
        repeat (3) @(negedge clk);
        chk("t2_dones", dones - b_dones, 1);

        // Upstream valid toggling during feed.
        @(posedge clk); #1;
        cfg_phase_mask = 8'h01;
        snap();
        pulse_run();
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(negedge clk);
                if (done) seen = 1;
                @(posedge clk); #1;
                src_vld = ~src_vld;
            end
            if (!seen) chk("t3_timeout", 0, 1);
        end
        src_vld = 1'b1;
        chk("t3_beats", beats - b_beats, 4);
        chk("t3_stall_seen", (stalls - b_stalls) > 0, 1);
        chk("t3_perf", perf_stall_cnt, PERF ? 32'(stalls - b_stalls) : 32'd0);

        // Empty mask: walk all slots, clear, done 11 cycles after run.
        @(posedge clk); #1;
        cfg_phase_mask = 8'h00;
        snap();
        pulse_run();
        wait_done("t4", 40, n);
        chk("t4_latency", n, 11);
        chk("t4_starts", starts - b_starts, 0);
        chk("t4_nupd", upd_n - b_upd, 1);
        chk("t4_upd0", upd_log[b_upd], 0);

        // Spurious finish_row while feeding.
        @(posedge clk); #1;
        cfg_phase_mask = 8'h01;
        src_vld = 1'b0;
        pulse_run();
        wait_rdy("t5", 50);
        @(posedge clk); #1 fr_force = 1;
        @(posedge clk); #1 fr_force = 0;
        @(negedge clk);
        chk("t5_err", err, 1);
        chk("t5_rowcnt", row_cnt, 0);
        chk("t5_rdy", src_rdy, 1);
        @(posedge clk); #1 src_vld = 1'b1;
        wait_done("t5", 200, n);
        chk("t5_err_sticky", err, 1);
        @(posedge clk); #1;
        cfg_phase_mask = 8'h00;
        pulse_run();
        @(negedge clk);
        chk("t5_err_clr", err, 0);
        wait_done("t5b", 40, n);

        // Reset in the middle of a feed.
        @(posedge clk); #1;
        wr_slot(0, 4, 2);
        cfg_phase_mask = 8'h01;
        src_vld = 1'b0;
        pulse_run();
        wait_rdy("t6", 50);
        @(posedge clk); #1 src_vld = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_rdy", src_rdy, 0);
        chk("t6_dvld", abuf_in_data_vld, 0);
        chk("t6_ctl", abuf_control_state, 0);
        chk("t6_upd", abuf_control_state_update, 0);
        chk("t6_start", abuf_start, 0);
        chk("t6_done", done, 0);
        chk("t6_rowcnt", row_cnt, 0);
        chk("t6_perf", perf_stall_cnt, 0);
        // Table was cleared: same mask now runs no phase.
        snap();
        @(posedge clk); #1;
        pulse_run();
        wait_done("t6a", 40, n);
        chk("t6_tbl_clr_starts", starts - b_starts, 0);
        @(posedge clk); #1;
        wr_slot(0, 2, 1);
        snap();
        pulse_run();
        wait_done("t6b", 200, n);
        chk("t6_beats", beats - b_beats, 2);
        chk("t6_starts", starts - b_starts, 1);
        chk("t6_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
